// File: rtl/cpu_pkg.sv
// Shared types and constants for the ID-stage operand forwarding scoreboard.
// Declares the per-stage writer tag, the stage index constants and the value
// of the forward-select field that means "read from the register file".
package cpu_pkg;

  localparam int unsigned SLOT_AW = 5;
  localparam int unsigned SLOT_SW = 2;

  localparam logic [SLOT_SW-1:0] STG_EX  = 2'd0;
  localparam logic [SLOT_SW-1:0] STG_MEM = 2'd1;
  localparam logic [SLOT_SW-1:0] STG_WB  = 2'd2;
  localparam logic [SLOT_SW-1:0] RF_SEL  = 2'd3;

  // One in-flight GPR writer: destination plus the slot at which its result is valid.
  typedef struct packed {
    logic               valid;
    logic [SLOT_AW-1:0] waddr;
    logic [SLOT_SW-1:0] rdy_stg;
  } fwd_slot_t;

endpackage

// File: rtl/fwd_port_sel.sv
// Combinational forwarding select for one ID read port.
// Ports:
//   rd_en, rd_addr  - read request of this port
//   rf_rdata        - register-file data for this port
//   slots           - in-flight writer tags, slot 0 youngest
//   stg_wdata       - result bus of every slot
//   rdata_c         - forwarded operand
//   fwd_sel_c       - slot forwarded from, or NSTG for register file
//   hazard_c        - youngest matching writer is not ready yet
module fwd_port_sel
  import cpu_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = SLOT_AW,
  parameter int unsigned NSTG = 3,
  parameter int unsigned SW   = SLOT_SW
) (
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_addr,
  input  logic [DW-1:0]           rf_rdata,
  input  fwd_slot_t [NSTG-1:0]    slots,
  input  logic [NSTG*DW-1:0]      stg_wdata,
  output logic [DW-1:0]           rdata_c,
  output logic [SW-1:0]           fwd_sel_c,
  output logic                    hazard_c
);

  localparam logic [SW-1:0] SEL_RF = SW'(NSTG);

  logic          hit;
  logic [SW-1:0] hit_k;
  logic [SW-1:0] hit_rdy;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit     = 1'b0;
    hit_k   = '0;
    hit_rdy = '0;
    for (int k = int'(NSTG) - 1; k >= 0; k--) begin
      if (slots[k].valid && (slots[k].waddr == SLOT_AW'(rd_addr))) begin
        hit     = 1'b1;
        hit_k   = SW'(k);
        hit_rdy = SW'(slots[k].rdy_stg);
      end
    end
  end

  // r0 and unused ports always take the register file and never stall.
  always_comb begin
    rdata_c   = rf_rdata;
    fwd_sel_c = SEL_RF;
    hazard_c  = 1'b0;
    if (rd_en && (rd_addr != '0) && hit) begin
      if (hit_k >= hit_rdy) begin
        rdata_c   = stg_wdata[32'(hit_k) * DW +: DW];
        fwd_sel_c = hit_k;
      end else begin
        hazard_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_fwd_scoreboard.sv
// ID-stage operand forwarding and RAW hazard unit.
// Tracks each in-flight GPR writer in a tag shift register that advances
// with the pipeline, forwards ready results to NRP read ports, raises a
// single stall request and counts stalled advance cycles.
// Ports:
//   clk_i, rst_i          - clock, async active-high reset
//   adv_i, flush_i        - pipeline advance / flush of youngest slots
//   issue_*               - writer tag of the instruction leaving ID
//   rd_en_i, rd_addr_i    - ID read ports
//   rf_rdata_i            - register-file read data
//   stg_wdata_i           - per-slot result buses
//   rdata_o, fwd_sel_o    - forwarded operands and their source (combinational)
//   stall_o               - ID must hold (combinational)
//   stall_cnt_o           - saturating stall-cycle counter
module id_fwd_scoreboard
  import cpu_pkg::*;
#(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = SLOT_AW,
  parameter int unsigned NRP         = 2,
  parameter int unsigned NSTG        = 3,
  parameter int unsigned SW          = SLOT_SW,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                adv_i,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  input  logic                issue_we_i,
  input  logic [AW-1:0]       issue_waddr_i,
  input  logic [SW-1:0]       issue_rdy_stg_i,
  input  logic [NRP-1:0]      rd_en_i,
  input  logic [NRP*AW-1:0]   rd_addr_i,
  input  logic [NRP*DW-1:0]   rf_rdata_i,
  input  logic [NSTG*DW-1:0]  stg_wdata_i,
  output logic [NRP*DW-1:0]   rdata_o,
  output logic [NRP*SW-1:0]   fwd_sel_o,
  output logic                stall_o,
  output logic [31:0]         stall_cnt_o
);

  fwd_slot_t [NSTG-1:0] slot_q, slot_d;
  logic [31:0]          stall_cnt_q, stall_cnt_d;
  logic [NRP-1:0]       hazard;
  logic                 capture;
  fwd_slot_t            issue_tag;

  // Per-port youngest-match search and ready check.
  for (genvar p = 0; p < int'(NRP); p++) begin : g_port
    fwd_port_sel #(
      .DW   (DW),
      .AW   (AW),
      .NSTG (NSTG),
      .SW   (SW)
    ) u_sel (
      .rd_en     (rd_en_i[p]),
      .rd_addr   (rd_addr_i[p*AW +: AW]),
      .rf_rdata  (rf_rdata_i[p*DW +: DW]),
      .slots     (slot_q),
      .stg_wdata (stg_wdata_i),
      .rdata_c   (rdata_o[p*DW +: DW]),
      .fwd_sel_c (fwd_sel_o[p*SW +: SW]),
      .hazard_c  (hazard[p])
    );
  end

  // A flushed ID instruction must not hold the pipeline.
  assign stall_o     = (|hazard) && !flush_i;
  assign stall_cnt_o = stall_cnt_q;

  assign capture = issue_valid_i && issue_we_i && (issue_waddr_i != '0) && !stall_o;

  always_comb begin
    issue_tag         = '0;
    issue_tag.valid   = 1'b1;
    issue_tag.waddr   = SLOT_AW'(issue_waddr_i);
    issue_tag.rdy_stg = SLOT_SW'(issue_rdy_stg_i);
  end

  // Slot update: flush kills the youngest slots, otherwise shift on advance.
  always_comb begin
    slot_d = slot_q;
    if (flush_i) begin
      if (adv_i) begin
        for (int unsigned k = 1; k < NSTG; k++) slot_d[k] = slot_q[k-1];
      end
      for (int unsigned k = 0; k < FLUSH_DEPTH; k++) slot_d[k] = '0;
    end else if (adv_i) begin
      for (int unsigned k = 1; k < NSTG; k++) slot_d[k] = slot_q[k-1];
      slot_d[0] = capture ? issue_tag : '0;
    end
  end

  // Stall counter saturates instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_o && adv_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      slot_q      <= slot_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
